modport_mem: RTL and testbench

Single-port, synchronous 2048 x 8 byte memory serving as the shared data store of the multiprocessor system. Processors and the verification environment access it through one clocked port: a write strobe, a read strobe, an 11-bit address and 8-bit data buses. Each completed read is flagged with a one-cycle valid pulse.

---
 rtl/modport_mem.sv | 71 +++++++
 tb/tb_modport_mem.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/modport_mem.sv
// -----------------------------------------------------------------------------
// modport_mem
//   Single-port synchronous byte memory used as the shared data store of the
//   multiprocessor system. One command is accepted per clock: a write, a read
//   or idle. Writes take priority over reads issued on the same edge. Read data
//   is registered and flagged by a one-cycle valid pulse.
//
// Ports
//   clk        in   single clock, all state changes on the rising edge
//   reset_n    in   synchronous active-low reset (clears outputs only)
//   data_in    in   write data, DATA_WIDTH bits
//   addr       in   word address, ADDR_WIDTH bits
//   we         in   write enable
//   read_en    in   read request (ignored while we=1)
//   data_out   out  registered read data, holds between reads
//   valid_out  out  high for the one cycle data_out carries a fresh result
// -----------------------------------------------------------------------------
module modport_mem #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;

    logic w_wr;
    logic w_rd;

    // Reset blocks both commands; a write outranks a read on the same edge.
    assign w_wr = reset_n && we;
    assign w_rd = reset_n && !we && read_en;

    // NOTE: the storage array has no reset branch on purpose: contents must
    // survive reset, and a reset term on the array would also stop it mapping
    // onto a block RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[addr] <= data_in;
        end
    end

    // Read port. Reads and writes are mutually exclusive on any edge, so the
    // old-data-on-collision behaviour never arises here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_rd;
            if (w_rd) begin
                r_data_out <= r_mem[addr];
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;

endmodule

// File: tb/tb_modport_mem.sv
// -----------------------------------------------------------------------------
// tb_modport_mem
//   Self-checking bench for modport_mem. A directed sequence covers reset,
//   priority, streaming and hold behaviour, then a randomized phase exercises
//   mixed traffic. Expected outputs come from a word-array model of the memory
//   that applies the command rules directly.
// -----------------------------------------------------------------------------
module tb_modport_mem;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] data_in;
    logic [AW-1:0] addr;
    logic          we;
    logic          read_en;
    logic [DW-1:0] data_out;
    logic          valid_out;

    modport_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .addr     (addr),
        .we       (we),
        .read_en  (read_en),
        .data_out (data_out),
        .valid_out(valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory contents plus a flag telling whether each word
    // has a defined value (power-up contents are undefined).
    logic [DW-1:0] model_mem   [DEPTH];
    bit            model_known [DEPTH];
    logic [DW-1:0] exp_data;
    bit            exp_data_known;
    logic          exp_valid;
    int            written_q [$];

    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Apply one command across one rising edge, advance the model, and compare
    // outputs shortly after the edge.
    task automatic step(input string tag, input logic rst_n_i, input logic we_i,
                        input logic re_i, input logic [AW-1:0] a_i, input logic [DW-1:0] d_i);
        reset_n = rst_n_i;
        we      = we_i;
        read_en = re_i;
        addr    = a_i;
        data_in = d_i;
        @(posedge clk);
        #1;
        if (!rst_n_i) begin
            exp_data       = '0;
            exp_data_known = 1'b1;
            exp_valid      = 1'b0;
        end else if (we_i) begin
            model_mem[a_i]   = d_i;
            model_known[a_i] = 1'b1;
            written_q.push_back(int'(a_i));
            exp_valid        = 1'b0;
        end else if (re_i) begin
            exp_data       = model_mem[a_i];
            exp_data_known = model_known[a_i];
            exp_valid      = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, exp_valid});
        if (exp_data_known) begin
            check({tag, ".data"}, {24'd0, data_out}, {24'd0, exp_data});
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        exp_data       = '0;
        exp_data_known = 1'b0;
        exp_valid      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model_known[i] = 1'b0;
        end
        reset_n = 1'b0;
        we      = 1'b0;
        read_en = 1'b0;
        addr    = '0;
        data_in = '0;

        // Reset held 2 cycles with both strobes active: outputs cleared, no write.
        step("reset0", 1'b0, 1'b1, 1'b1, 11'h005, 8'hFF);
        step("reset1", 1'b0, 1'b1, 1'b1, 11'h005, 8'hFF);
        check("reset.data_zero", {24'd0, data_out}, 32'h0);
        step("idle0", 1'b1, 1'b0, 1'b0, 11'h000, 8'h00);

        // Write then read the lowest and highest addresses.
        step("wr_000", 1'b1, 1'b1, 1'b0, 11'h000, 8'hA5);
        step("wr_7ff", 1'b1, 1'b1, 1'b0, 11'h7FF, 8'h3C);
        step("rd_000", 1'b1, 1'b0, 1'b1, 11'h000, 8'h00);
        step("rd_7ff", 1'b1, 1'b0, 1'b1, 11'h7FF, 8'h00);
        step("rd_end", 1'b1, 1'b0, 1'b0, 11'h000, 8'h00);

        // Write wins over a simultaneous read; data_out holds 8'h3C.
        step("wr_rd_010", 1'b1, 1'b1, 1'b1, 11'h010, 8'h77);
        check("collide.hold", {24'd0, data_out}, 32'h3C);
        step("rd_010", 1'b1, 1'b0, 1'b1, 11'h010, 8'h00);

        // Preload and stream four back-to-back reads.
        for (int i = 1; i <= 4; i++) begin
            step("preload", 1'b1, 1'b1, 1'b0, AW'(i), DW'(i * 8'h11));
        end
        for (int i = 1; i <= 4; i++) begin
            step("stream", 1'b1, 1'b0, 1'b1, AW'(i), 8'h00);
        end

        // Idle hold after a read returning 8'h5A.
        step("wr_5a", 1'b1, 1'b1, 1'b0, 11'h020, 8'h5A);
        step("rd_5a", 1'b1, 1'b0, 1'b1, 11'h020, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step("idle_hold", 1'b1, 1'b0, 1'b0, 11'h020, 8'h00);
        end
        check("idle_hold.data", {24'd0, data_out}, 32'h5A);

        // Memory survives a one-cycle reset pulse.
        step("wr_c3", 1'b1, 1'b1, 1'b0, 11'h123, 8'hC3);
        step("pulse_rst", 1'b0, 1'b0, 1'b1, 11'h123, 8'h00);
        step("rd_123", 1'b1, 1'b0, 1'b1, 11'h123, 8'h00);

        // The write attempted under reset must not have landed.
        step("rd_005", 1'b1, 1'b0, 1'b1, 11'h005, 8'h00);
        checks++;
        assert (data_out !== 8'hFF) else begin
            failures++;
            $error("FAIL reset_no_write observed=%0h expected=not ff", data_out);
        end

        // Randomized mixed traffic; reads only target defined words.
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [AW-1:0] a;
            op = $urandom_range(0, 99);
            if (op < 3) begin
                step("rnd_rst", 1'b0, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
            end else if (op < 40) begin
                step("rnd_wr", 1'b1, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom));
            end else if (op < 85) begin
                a = AW'(written_q[$urandom_range(0, written_q.size() - 1)]);
                step("rnd_rd", 1'b1, 1'b0, 1'b1, a, DW'($urandom));
            end else begin
                step("rnd_idle", 1'b1, 1'b0, 1'b0, AW'($urandom), DW'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
